// File: rtl/flag_xfer_sched.sv
// flag_xfer_sched
//
// Shares one toggle-synchronizer flag channel among NREQ requesters in the clkA
// domain. Single-cycle request pulses are collected in a pending register, one is
// picked round-robin, and a one-cycle flag pulse plus a stable requester ID are
// sent toward the crossing. A guard gap then keeps consecutive pulses far enough
// apart for the receive side to resolve them.
//
// Build option: define FLAG_XFER_SCHED_ACK_EN to compile in the WAIT_ACK state,
// the ack latch and the ack timeout counter. Without it Ack_clkA is ignored,
// Timeout_clkA stays 0 and ISSUE goes straight to GAP.
//
// Ports:
//   clkA          sole clock
//   rstA_n        asynchronous active-low reset
//   Req_clkA      per-requester single-cycle request pulses
//   Ack_clkA      return-flag pulse, already synchronized into clkA
//   FlagOut_clkA  one-cycle pulse into the flag crossing
//   Id_clkA       index of the last granted requester, held between pulses
//   Grant_clkA    one-hot grant pulse, coincident with FlagOut_clkA
//   Busy_clkA     high whenever the scheduler is not idle
//   Overrun_clkA  pulse per requester whose request was coalesced
//   Timeout_clkA  pulse when the ack wait expired

module flag_xfer_sched #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned IDW     = 2,
    parameter int unsigned GAP     = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clkA,
    input  logic            rstA_n,
    input  logic [NREQ-1:0] Req_clkA,
    input  logic            Ack_clkA,
    output logic            FlagOut_clkA,
    output logic [IDW-1:0]  Id_clkA,
    output logic [NREQ-1:0] Grant_clkA,
    output logic            Busy_clkA,
    output logic [NREQ-1:0] Overrun_clkA,
    output logic            Timeout_clkA
);

`ifdef FLAG_XFER_SCHED_ACK_EN
    localparam int unsigned CntMax = (TIMEOUT > GAP) ? TIMEOUT : GAP;
`else
    localparam int unsigned CntMax = GAP;
`endif
    // The counter only ever holds values up to CntMax-1.
    localparam int unsigned CW = (CntMax > 1) ? $clog2(CntMax) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitAck,
        StGap
    } state_e;

    state_e          state;
    logic [NREQ-1:0] pend;
    logic [IDW-1:0]  ptr;
    logic [CW-1:0]   cnt;

`ifdef FLAG_XFER_SCHED_ACK_EN
    logic            ackLatch;
`else
    logic            unusedNoAck;
    assign unusedNoAck = Ack_clkA | (TIMEOUT == 0);
`endif

    logic            anyPend;
    logic [IDW-1:0]  pickIdx;
    logic [IDW-1:0]  nextPtr;
    logic [NREQ-1:0] clrMask;
    logic [NREQ-1:0] pendNext;
    logic [NREQ-1:0] overrunNext;
    logic            startIssue;

    assign anyPend = |pend;

    // Round-robin pick: the lowest pending index overall is the wrap-around
    // fallback, overridden by the lowest pending index at or after ptr.
    always_comb begin
        pickIdx = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (pend[i]) begin
                pickIdx = IDW'(i);
            end
        end
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (pend[i] && (IDW'(i) >= ptr)) begin
                pickIdx = IDW'(i);
            end
        end
    end

    assign nextPtr = (pickIdx == IDW'(NREQ - 1)) ? '0 : pickIdx + 1'b1;

    // The granted bit is cleared on the edge that leaves ISSUE; a new request
    // on that same edge wins, so it is served again later.
    assign clrMask     = (state == StIssue) ? Grant_clkA : '0;
    assign pendNext    = (pend & ~clrMask) | Req_clkA;
    assign overrunNext = Req_clkA & pend & ~clrMask;

    // The grant decision is taken from the registered pend on the way into ISSUE.
    assign startIssue = anyPend &&
                        ((state == StIdle) || ((state == StGap) && (cnt == '0)));

    always_ff @(posedge clkA or negedge rstA_n) begin
        if (!rstA_n) begin
            state        <= StIdle;
            pend         <= '0;
            ptr          <= '0;
            cnt          <= '0;
            FlagOut_clkA <= 1'b0;
            Id_clkA      <= '0;
            Grant_clkA   <= '0;
            Busy_clkA    <= 1'b0;
            Overrun_clkA <= '0;
            Timeout_clkA <= 1'b0;
`ifdef FLAG_XFER_SCHED_ACK_EN
            ackLatch     <= 1'b0;
`endif
        end else begin
            pend         <= pendNext;
            Overrun_clkA <= overrunNext;
            FlagOut_clkA <= 1'b0;
            Grant_clkA   <= '0;
            Timeout_clkA <= 1'b0;
`ifdef FLAG_XFER_SCHED_ACK_EN
            ackLatch     <= 1'b0;
`endif

            unique case (state)
                StIdle: begin
                    // Leaving IDLE is handled by startIssue below.
                end
                StIssue: begin
`ifdef FLAG_XFER_SCHED_ACK_EN
                    // An ack already here is held so WAIT_ACK exits after one cycle.
                    ackLatch <= Ack_clkA;
                    cnt      <= '0;
                    state    <= StWaitAck;
`else
                    cnt      <= CW'(GAP - 1);
                    state    <= StGap;
`endif
                end
                StWaitAck: begin
`ifdef FLAG_XFER_SCHED_ACK_EN
                    if (Ack_clkA || ackLatch) begin
                        cnt   <= CW'(GAP - 1);
                        state <= StGap;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        Timeout_clkA <= 1'b1;
                        cnt          <= CW'(GAP - 1);
                        state        <= StGap;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`else
                    state <= StIdle;
`endif
                end
                StGap: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (!anyPend) begin
                        state     <= StIdle;
                        Busy_clkA <= 1'b0;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase

            if (startIssue) begin
                state        <= StIssue;
                FlagOut_clkA <= 1'b1;
                Grant_clkA   <= NREQ'(1) << pickIdx;
                Id_clkA      <= pickIdx;
                ptr          <= nextPtr;
                Busy_clkA    <= 1'b1;
            end
        end
    end

endmodule

// File: doc/flag_xfer_sched.md
# flag_xfer_sched

Single-clock scheduler that shares one toggle-synchronizer flag channel among NREQ requesters in the clkA domain. It collects single-cycle request pulses, picks one by round-robin, emits one flag pulse plus a stable requester ID toward the crossing, then enforces a guard gap so consecutive pulses are never closer than the receive side can resolve. It sits directly in front of the flag crossing; the ID bus is quasi-static and is sampled on the far side when the flag arrives.

## Interface
- NREQ, 4: number of requesters (2..16)
- IDW, 2: ID width, ceil(log2(NREQ)), minimum 1
- GAP, 4: guard cycles after each pulse (1..255)
- TIMEOUT, 255: ack wait limit in cycles (1..65535); used only with FLAG_XFER_SCHED_ACK_EN
- clkA  in  1  sole clock
- rstA_n  in  1  reset, asynchronous assert, active-low
- Req_clkA  in  NREQ  per-requester single-cycle request pulses
- Ack_clkA  in  1  return-flag pulse, already synchronized into clkA; ignored without the macro
- FlagOut_clkA  out  1  one-cycle pulse into the flag crossing
- Id_clkA  out  IDW  index of the last granted requester; held between pulses
- Grant_clkA  out  NREQ  one-hot pulse, coincident with FlagOut_clkA
- Busy_clkA  out  1  high in any state other than IDLE
- Overrun_clkA  out  NREQ  pulse: request hit an already-pending bit (coalesced)
- Timeout_clkA  out  1  pulse: ack wait expired

## Operation
- Pending register pend[NREQ]: bit i sets on Req_clkA[i] and clears when i is granted. If set and clear occur in the same cycle, set wins, so the request stays pending.
- Overrun_clkA[i] pulses the cycle after Req_clkA[i] arrives while pend[i] is already 1 and is not being cleared that cycle.
- Round-robin pointer ptr (IDW bits, reset 0). The grant goes to the first pending index at or after ptr, wrapping modulo NREQ. After granting i, ptr = (i+1) mod NREQ.
- States:
  - IDLE: if any pend bit is set, go to ISSUE.
  - ISSUE (1 cycle): FlagOut_clkA=1, Grant_clkA one-hot, Id_clkA updated. Go to WAIT_ACK if the macro is defined, otherwise go to GAP with cnt=GAP-1.
  - WAIT_ACK: on Ack_clkA, go to GAP. If cnt reaches TIMEOUT-1 with no ack, pulse Timeout_clkA and go to GAP.
  - GAP: cnt counts down. At 0, go to ISSUE if any pend bit is set, otherwise go to IDLE.
- The grant decision is made from the registered pend at the transition into ISSUE. Outputs in ISSUE are registered.
- Reset values: state=IDLE, pend=0, ptr=0, cnt=0, Id_clkA=0, all pulse outputs 0, Busy_clkA=0.
- Reset mid-operation: all pending requests are discarded. A pulse already emitted stays emitted, with no retraction.

## Timing
- Latency: Req_clkA[i] high at edge k → pend[i]=1 after k → ISSUE after edge k+1. FlagOut_clkA is high in cycle k+2 when starting from IDLE.
- Spacing without ack: rising cycles of consecutive FlagOut_clkA pulses are at least GAP+1 cycles apart. This holds exactly when requests are back-to-back.
- With ack: spacing is 1 + (cycles until ack, inclusive) + GAP.
- An ack arriving in the ISSUE cycle is latched and consumed on entry to WAIT_ACK, so WAIT_ACK lasts 1 cycle.
- Acks arriving outside ISSUE/WAIT_ACK are ignored and produce no error.
- Id_clkA changes only on an ISSUE edge. It is stable for the whole gap so the far side can sample it.
- Requests arriving during GAP or WAIT_ACK are held in pend; none is lost except by coalescing.

## Configuration
- FLAG_XFER_SCHED_ACK_EN defined:
  - WAIT_ACK state, ack latch and timeout counter are compiled in.
  - Each pulse must be acknowledged or must time out before the gap starts.
- Undefined:
  - Ack_clkA is ignored and Timeout_clkA is tied to 0.
  - ISSUE goes directly to GAP, and the counter width covers GAP only.

## Test plan
- Reset state: assert rstA_n=0 with Req_clkA=4'b1111 → all outputs 0. After release with requests held low, FlagOut_clkA stays 0 and Busy_clkA=0.
- Single request, GAP=4: Req_clkA=4'b0100 at edge 10 → FlagOut_clkA=1 and Grant_clkA=4'b0100 in cycle 12, Id_clkA=2 stable afterwards, Busy_clkA low again by cycle 17.
- Fairness: Req_clkA=4'b1111 in one cycle, GAP=4, no macro → grants in order 0,1,2,3 at cycles 2,7,12,17. A repeated request from 0 during that run is served after 3.
- Coalesce/overrun: Req_clkA[1] pulsed at cycles 0 and 1 while idle → exactly one grant for 1, Overrun_clkA[1] pulse in cycle 2. A request landing in the same cycle as its own grant yields a second grant.
- Ack mode (macro), TIMEOUT=8: grant in cycle 2, Ack_clkA in cycle 5 → GAP starts cycle 6. In a second run with no ack → Timeout_clkA pulse, then GAP, then the next pending grant proceeds.
- Async reset mid-GAP with pend=4'b1010 → outputs 0 immediately. After release there are no grants until a new request.
